// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: writeback FSM state,
// trap cause codes and access-size encodings.
package riscv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } wb_state_t;

  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_FAULT     = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_STORE_FAULT    = 4'd7;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // A doubleword request on a 32-bit core degrades to a word.
  function automatic logic [1:0] eff_size(
    input logic [2:0] sz,
    input int         xlen
  );
    logic [1:0] s;
    s = sz[1:0];
    if (xlen == 32 && s == SZ_D) s = SZ_W;
    return s;
  endfunction

endpackage

// File: rtl/memwb_if.sv
// Data-memory bus between the writeback stage (master)
// and the memory system (slave).
interface memwb_if #(
  parameter int XLEN = 64
);

  logic              valid;
  logic              we;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic [XLEN/8-1:0] wstrb;
  logic              ready;
  logic [XLEN-1:0]   rdata;
  logic              error;

  modport master (
    output valid, we, addr, wdata, wstrb,
    input  ready, rdata, error
  );

  modport slave (
    input  valid, we, addr, wdata, wstrb,
    output ready, rdata, error
  );

endinterface

// File: rtl/memwb_load_align.sv
// Load data alignment: shift the bus word down to the addressed
// byte, then sign- or zero-extend from the access size.
module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int OB   = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [OB-1:0]   i_offset,
  input  logic [1:0]      i_size,
  input  logic            i_signed,
  output logic [XLEN-1:0] o_result
);

  logic [XLEN-1:0] w_sh;

  always_comb begin
    w_sh     = i_rdata >> {i_offset, 3'b000};
    o_result = w_sh;
    unique case (1'b1)
      (i_size == SZ_B):
        o_result = i_signed ? XLEN'($signed(w_sh[7:0]))
                            : XLEN'(w_sh[7:0]);
      (i_size == SZ_H):
        o_result = i_signed ? XLEN'($signed(w_sh[15:0]))
                            : XLEN'(w_sh[15:0]);
      (i_size == SZ_W):
        o_result = i_signed ? XLEN'($signed(w_sh[31:0]))
                            : XLEN'(w_sh[31:0]);
      default:
        o_result = w_sh;
    endcase
  end

endmodule

// File: rtl/memwb.sv
// Writeback stage: data-bus handshake, store lane alignment, load
// extraction, RF/CSR retire and trap report. Option: MISALIGN_TRAP_EN.
module memwb
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_read_req,
  input  logic              mem_write_req,
  input  logic [2:0]        mem_size,
  input  logic              mem_signed,
  input  logic [4:0]        rd,
  input  logic              reg_write_enable,
  input  logic [XLEN-1:0]   writeback_data,
  input  logic [XLEN-1:0]   pc,
  input  logic              exception_occurred,
  input  logic [3:0]        exception_cause,
  input  logic [11:0]       csr_addr,
  input  logic [XLEN-1:0]   csr_wdata,
  input  logic              csr_write,
  memwb_if.master           bus,
  output logic              stall_out,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              csr_we,
  output logic [11:0]       csr_waddr,
  output logic [XLEN-1:0]   csr_wdata_out,
  output logic              trap_valid,
  output logic [XLEN-1:0]   trap_pc,
  output logic [3:0]        trap_cause
);

  localparam int NB = XLEN/8;
  localparam int OB = $clog2(NB);

  wb_state_t         r_state;
  logic              r_bus_we;
  logic [XLEN-1:0]   r_bus_addr;
  logic [XLEN-1:0]   r_bus_wdata;
  logic [NB-1:0]     r_bus_wstrb;
  logic              r_kill;
  logic [OB-1:0]     r_off;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [4:0]        r_rd;
  logic              r_rwe;
  logic [XLEN-1:0]   r_pc;
  logic              r_csr_w;
  logic [11:0]       r_csr_a;
  logic [XLEN-1:0]   r_csr_d;

  logic              r_rf_we;
  logic [4:0]        r_rf_waddr;
  logic [XLEN-1:0]   r_rf_wdata;
  logic              r_csr_we;
  logic [11:0]       r_csr_waddr;
  logic [XLEN-1:0]   r_csr_wdata;
  logic              r_trap_valid;
  logic [XLEN-1:0]   r_trap_pc;
  logic [3:0]        r_trap_cause;

  logic [1:0]        w_size;
  logic [OB-1:0]     w_off;
  logic              w_mem_op;
  logic              w_mis;
  logic              w_start;
  logic              w_kill;
  logic [15:0]       w_mask;
  logic [NB-1:0]     w_strb;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_load;
`ifdef MISALIGN_TRAP_EN
  logic [OB-1:0]     w_amask;
`endif

  always_comb begin
    w_size   = eff_size(mem_size, XLEN);
    w_off    = mem_addr[OB-1:0];
    w_mem_op = mem_read_req | mem_write_req;
`ifdef MISALIGN_TRAP_EN
    w_amask  = OB'((4'd1 << w_size) - 4'd1);
    w_mis    = w_mem_op && (|(w_off & w_amask));
`else
    w_mis    = 1'b0;
`endif
    w_start  = (r_state == IDLE) && w_mem_op
             && !exception_occurred && !flush && !w_mis;
    // Lanes pushed past the top byte fall off the truncation.
    w_mask   = (16'd1 << (5'd1 << w_size)) - 16'd1;
    w_strb   = NB'(w_mask << w_off);
    w_wdata  = mem_wdata << {w_off, 3'b000};
    w_kill   = r_kill | flush;
    stall_out = (r_state == IDLE) ? w_start : !bus.ready;
  end

  load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .i_rdata  (bus.rdata),
    .i_offset (r_off),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_result (w_load)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_bus_wstrb  <= '0;
      r_kill       <= 1'b0;
      r_off        <= '0;
      r_size       <= SZ_B;
      r_signed     <= 1'b0;
      r_rd         <= '0;
      r_rwe        <= 1'b0;
      r_pc         <= '0;
      r_csr_w      <= 1'b0;
      r_csr_a      <= '0;
      r_csr_d      <= '0;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_csr_we     <= 1'b0;
      r_csr_waddr  <= '0;
      r_csr_wdata  <= '0;
      r_trap_valid <= 1'b0;
      r_trap_pc    <= '0;
      r_trap_cause <= '0;
    end else begin
      r_rf_we      <= 1'b0;
      r_csr_we     <= 1'b0;
      r_trap_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state     <= BUSY;
            r_bus_we    <= mem_write_req;
            r_bus_addr  <= {mem_addr[XLEN-1:OB], {OB{1'b0}}};
            r_bus_wdata <= w_wdata;
            r_bus_wstrb <= w_strb;
            r_kill      <= 1'b0;
            r_off       <= w_off;
            r_size      <= w_size;
            r_signed    <= mem_signed;
            r_rd        <= rd;
            r_rwe       <= reg_write_enable;
            r_pc        <= pc;
            r_csr_w     <= csr_write;
            r_csr_a     <= csr_addr;
            r_csr_d     <= csr_wdata;
          end else if (!flush) begin
            r_rf_waddr  <= rd;
            r_rf_wdata  <= writeback_data;
            r_csr_waddr <= csr_addr;
            r_csr_wdata <= csr_wdata;
            r_trap_pc   <= pc;
            if (exception_occurred) begin
              r_trap_valid <= 1'b1;
              r_trap_cause <= exception_cause;
            end else if (w_mis) begin
              r_trap_valid <= 1'b1;
              r_trap_cause <= mem_write_req ? CAUSE_STORE_MISALIGN
                                            : CAUSE_LOAD_MISALIGN;
            end else begin
              r_rf_we  <= reg_write_enable && (|rd);
              r_csr_we <= csr_write;
            end
          end
        end
        BUSY: begin
          r_kill <= w_kill;
          if (bus.ready) begin
            r_state     <= IDLE;
            r_kill      <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
            r_rf_waddr  <= r_rd;
            r_rf_wdata  <= w_load;
            r_csr_waddr <= r_csr_a;
            r_csr_wdata <= r_csr_d;
            r_trap_pc   <= r_pc;
            // A flushed access still drains the bus but leaves no trace.
            if (!w_kill) begin
              if (bus.error) begin
                r_trap_valid <= 1'b1;
                r_trap_cause <= r_bus_we ? CAUSE_STORE_FAULT
                                         : CAUSE_LOAD_FAULT;
              end else begin
                r_rf_we  <= !r_bus_we && r_rwe && (|r_rd);
                r_csr_we <= r_csr_w;
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.valid     = (r_state == BUSY);
  assign bus.we        = r_bus_we;
  assign bus.addr      = r_bus_addr;
  assign bus.wdata     = r_bus_wdata;
  assign bus.wstrb     = r_bus_wstrb;

  assign rf_we         = r_rf_we;
  assign rf_waddr      = r_rf_waddr;
  assign rf_wdata      = r_rf_wdata;
  assign csr_we        = r_csr_we;
  assign csr_waddr     = r_csr_waddr;
  assign csr_wdata_out = r_csr_wdata;
  assign trap_valid    = r_trap_valid;
  assign trap_pc       = r_trap_pc;
  assign trap_cause    = r_trap_cause;

endmodule

// File: doc/memwb.md
# memwb

Writeback stage of the RISC-V pipeline, directly downstream of the memory-access stage. It consumes that stage's registered request and control outputs. It runs the data-memory bus handshake, stalling upstream until the access completes. It aligns store data into byte lanes and extracts and extends load data. It then drives the register-file write port, the CSR write port and the trap report.

## Interface
Parameters:
- XLEN, 64, data/address width; 32 or 64.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  kill current/in-flight instruction's architectural effects
- mem_addr  in  XLEN  effective address / ALU result
- mem_wdata  in  XLEN  store data, unaligned (LSB-justified)
- mem_read_req, mem_write_req  in  1 each  load / store request
- mem_size  in  3  0=B,1=H,2=W,3=D
- mem_signed  in  1  sign-extend load
- rd  in  5  destination register
- reg_write_enable  in  1  instruction writes rd
- writeback_data  in  XLEN  non-load result
- pc  in  XLEN  instruction PC
- exception_occurred  in  1  upstream trap
- exception_cause  in  4  upstream cause
- csr_addr  in  12  CSR address
- csr_wdata  in  XLEN  CSR write data
- csr_write  in  1  CSR write request
- bus_valid  out  1  bus request valid
- bus_we  out  1  1=store
- bus_addr  out  XLEN  mem_addr with low log2(XLEN/8) bits cleared
- bus_wdata  out  XLEN  lane-shifted store data
- bus_wstrb  out  XLEN/8  byte enables
- bus_ready  in  1  response/accept strobe
- bus_rdata  in  XLEN  full-width read data
- bus_error  in  1  access fault, qualified by bus_ready
- stall_out  out  1  combinational; holds upstream stages
- rf_we  out  1  register write enable (suppressed for rd=0)
- rf_waddr  out  5  register index
- rf_wdata  out  XLEN  register data
- csr_we  out  1  CSR write enable
- csr_waddr  out  12  CSR address
- csr_wdata_out  out  XLEN  CSR data
- trap_valid  out  1  one-cycle trap report
- trap_pc  out  XLEN  faulting PC
- trap_cause  out  4  cause code

## Operation
- FSM states: IDLE, BUSY. Reset: IDLE. All outputs are 0 at reset; bus_* is 0 in IDLE.
- IDLE, no memory op, or exception_occurred=1:
  - Retire registered at the next edge.
  - rf_* from writeback_data.
  - csr_* passes through.
  - trap_valid = exception_occurred, with trap_pc = pc and trap_cause = exception_cause; rf_we and csr_we are forced to 0.
- IDLE with a memory op and no trap: stall_out=1; transition to BUSY.
- BUSY:
  - bus_valid=1, with addr, we, wdata and wstrb registered on entry and held stable until bus_ready.
  - stall_out = !bus_ready.
  - On bus_ready: state goes to IDLE and retire is registered.
  - Load: rf_wdata = extend(bus_rdata >> 8*offset, size, signed), where offset = mem_addr[log2(XLEN/8)-1:0].
  - Store: rf_we=0.
  - With bus_error: no rf_we; trap cause 5 for a load, 7 for a store.
- Store lanes: bus_wdata = mem_wdata << 8*offset; bus_wstrb = ((1<<2^size)-1) << offset, truncated to XLEN/8 bits.
- mem_size=3 with XLEN=32 is treated as size 2.
- flush:
  - In IDLE, it suppresses the retire and does not start a bus op.
  - In BUSY, it sets a kill flag. The transaction still completes, but rf_we, csr_we and trap_valid are suppressed at completion.
- Retire outputs (rf_we, csr_we, trap_valid) are high for exactly one cycle per instruction.

## Timing
- Non-memory op visible in cycle 0 → retire outputs valid in cycle 1.
- Memory op visible in cycle 0 → stall_out=1 in cycle 0; bus_valid first high in cycle 1; bus_ready in cycle k≥1 → rf_we in cycle k+1.
- stall_out falls in the same cycle bus_ready is seen, so upstream advances on that edge.
- resetn asserted mid-BUSY: the FSM returns to IDLE immediately and bus_valid drops; the bus slave must tolerate the abandoned request.

## Configuration
- MISALIGN_TRAP_EN defined:
  - An access with mem_addr mod 2^size ≠ 0 takes no bus transaction.
  - It retires in one cycle with trap_valid=1: cause 4 for a load, 6 for a store.
- Undefined: no check is made. Lanes beyond XLEN/8 are dropped from wstrb, and load data is taken from the shifted word with zero fill.

## Structure
- Shared package riscv_pkg holds:
  - the wb_state_t enum (IDLE, BUSY);
  - cause constants CAUSE_LOAD_MISALIGN=4, CAUSE_LOAD_FAULT=5, CAUSE_STORE_MISALIGN=6, CAUSE_STORE_FAULT=7;
  - the size encodings.
- Sub-module load_align: combinational shift plus sign/zero extension (rdata, offset, size, signed → XLEN result). It is reused by a future LSU.

## Test plan
- XLEN=64, LW at 0x1004, mem_signed=1, bus_rdata=0x8765_4321_0000_0000, bus_ready after 3 cycles → rf_wdata=0xFFFF_FFFF_8765_4321; stall_out high for 3 cycles; rf_we high for 1 cycle.
- LBU at 0x1007 with the same rdata → rf_wdata=0x87; bus_addr=0x1000.
- SB at 0x1003, mem_wdata=0xAB → bus_wdata=0x0000_0000_AB00_0000, bus_wstrb=0x08, rf_we=0.
- With MISALIGN_TRAP_EN: LW at 0x1002, pc=0x200 → no bus_valid; next cycle trap_valid=1, trap_cause=4, trap_pc=0x200.
- SD with bus_ready & bus_error → trap_cause=7, no rf_we.
- LD with flush pulsed in the second BUSY cycle and bus_ready in the fourth → bus_valid held until ready; rf_we and trap_valid never asserted; next ADD retires normally.
